// File: rtl/rgb2ycbcr_pipe.sv
// rtl/rgb2ycbcr_pipe.sv - pipelined BT.601 full-range RGB->YCbCr with gray/444/422/bypass output
// Optional CHROMA_AVG_EN: 4:2:2 chroma pair averaging, one extra stage (LAT 5 instead of 4).
module rgb2ycbcr_pipe #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      cfg_mode,
  input  logic            pre_frame_vsync,
  input  logic            pre_frame_hsync,
  input  logic            pre_frame_de,
  input  logic [3*DW-1:0] img_data,
  output logic            post_frame_vsync,
  output logic            post_frame_hsync,
  output logic            post_frame_de,
  output logic [3*DW-1:0] post_data,
  output logic [1:0]      mode_active
);
  localparam int PW  = DW + 8;
  localparam int AW  = DW + 10;
  localparam int SBW = 3*DW + 5;
`ifdef CHROMA_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 3;
`endif
  localparam logic signed [AW-1:0] C_OFS = AW'((1 << (DW+7)) + 128);
  localparam logic signed [AW-1:0] Y_RND = AW'(128);
  localparam logic signed [DW+1:0] MAXV  = {2'b00, {DW{1'b1}}};

  logic                 vs_d;
  logic [SBW-1:0]       sb [NS];
  logic [PW-1:0]        r_e, g_e, b_e;
  logic [PW-1:0]        m_yr, m_yg, m_yb, m_cbr, m_cbg, m_cbb, m_crr, m_crg, m_crb;
  logic signed [AW-1:0] s_y, s_cb, s_cr;
  logic [DW-1:0]        y3, cb3, cr3;
  logic [DW-1:0]        py, pcb, pcr, c_hold, chroma;
  logic                 phase;
  logic                 o_vs, o_hs, o_de;
  logic [1:0]           o_mode;
  logic [3*DW-1:0]      o_rgb, packed_px;

  assign r_e = PW'(img_data[3*DW-1 -: DW]);
  assign g_e = PW'(img_data[2*DW-1 -: DW]);
  assign b_e = PW'(img_data[DW-1:0]);

  function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] a);
    logic signed [DW+1:0] q;
    q = a[AW-1:8];
    if (q < 0)         sat = '0;
    else if (q > MAXV) sat = '1;
    else               sat = q[DW-1:0];
  endfunction

  // Mode is sampled only on a vsync rising edge so a frame never mixes formats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d        <= 1'b0;
      mode_active <= 2'd0;
    end else begin
      vs_d <= pre_frame_vsync;
      if (pre_frame_vsync && !vs_d) mode_active <= cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) sb[i] <= '0;
      {m_yr, m_yg, m_yb, m_cbr, m_cbg, m_cbb, m_crr, m_crg, m_crb} <= '0;
      {s_y, s_cb, s_cr} <= '0;
      {y3, cb3, cr3}    <= '0;
    end else begin
      sb[0] <= {pre_frame_vsync, pre_frame_hsync, pre_frame_de, mode_active, img_data};
      for (int i = 1; i < NS; i++) sb[i] <= sb[i-1];
      m_yr  <= r_e * PW'(77);
      m_yg  <= g_e * PW'(150);
      m_yb  <= b_e * PW'(29);
      m_cbr <= r_e * PW'(43);
      m_cbg <= g_e * PW'(85);
      m_cbb <= b_e << 7;
      m_crr <= r_e << 7;
      m_crg <= g_e * PW'(107);
      m_crb <= b_e * PW'(21);
      s_y   <= AW'(m_yr) + AW'(m_yg) + AW'(m_yb) + Y_RND;
      s_cb  <= AW'(m_cbb) - AW'(m_cbr) - AW'(m_cbg) + C_OFS;
      s_cr  <= AW'(m_crr) - AW'(m_crg) - AW'(m_crb) + C_OFS;
      y3    <= sat(s_y);
      cb3   <= sat(s_cb);
      cr3   <= sat(s_cr);
    end
  end

  assign {o_vs, o_hs, o_de, o_mode, o_rgb} = sb[NS-1];

`ifdef CHROMA_AVG_EN
  logic [DW-1:0] y4, cb4, cr4;
  logic          next_de;

  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s   = {1'b0, a} + {1'b0, b} + (DW+1)'(1);
    avg = s[DW:1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {y4, cb4, cr4} <= '0;
    else        {y4, cb4, cr4} <= {y3, cb3, cr3};
  end

  assign {py, pcb, pcr} = {y4, cb4, cr4};
  // S3 holds the following pixel, so the even pixel can look one ahead
  assign next_de = sb[NS-2][3*DW+2];

  always_comb begin
    chroma = pcb;
    if (!phase) chroma = next_de ? avg(pcb, cb3) : pcb;
    else        chroma = avg(c_hold, pcr);
  end
`else
  assign {py, pcb, pcr} = {y3, cb3, cr3};

  always_comb begin
    chroma = pcb;
    if (phase) chroma = c_hold;
  end
`endif

  always_comb begin
    packed_px = '0;
    case (o_mode)
      2'd0:    packed_px = {py, py, py};
      2'd1:    packed_px = {py, pcb, pcr};
      2'd2:    packed_px = {py, chroma, {DW{1'b0}}};
      default: packed_px = o_rgb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
      post_data        <= '0;
      phase            <= 1'b0;
      c_hold           <= '0;
    end else begin
      post_frame_vsync <= o_vs;
      post_frame_hsync <= o_hs;
      post_frame_de    <= o_de;
      post_data        <= o_de ? packed_px : '0;
      phase            <= o_de ? ~phase : 1'b0;
      if (o_de && !phase) c_hold <= pcr;
    end
  end
endmodule
